// File: rtl/mem_arbiter.sv
// Arbitrates the icache (port 0) and dcache (port 1) onto one word-granular memory port.
// The bus stays locked to one owner until its reads drain; writes that cannot issue are posted.
module mem_arbiter #(
  parameter int unsigned OUT_W = 3
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_p0_ren,
  input  logic        i_p0_wen,
  input  logic [31:0] i_p0_addr,
  input  logic [31:0] i_p0_wdata,
  output logic        o_p0_ready,
  output logic [31:0] o_p0_rdata,
  output logic        o_p0_valid,
  input  logic        i_p1_ren,
  input  logic        i_p1_wen,
  input  logic [31:0] i_p1_addr,
  input  logic [31:0] i_p1_wdata,
  output logic        o_p1_ready,
  output logic [31:0] o_p1_rdata,
  output logic        o_p1_valid,
  input  logic        i_mem_ready,
  output logic [31:0] o_mem_addr,
  output logic        o_mem_ren,
  output logic        o_mem_wen,
  output logic [31:0] o_mem_wdata,
  input  logic [31:0] i_mem_rdata,
  input  logic        i_mem_valid,
  output logic        o_err
);

  localparam int unsigned DW = 32;
  localparam logic [OUT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_t;
  typedef struct packed {
    logic          full;
    logic [DW-1:0] addr;
    logic [DW-1:0] data;
  } post_t;

  state_t           state, state_next;
  logic             last_owner, last_owner_next;
  post_t            post_buf [2];
  logic [OUT_W-1:0] out_cnt, out_cnt_next;
  logic             err, err_next;

  logic [1:0]    ren, wen, req, full, issued, post, drain;
  logic [DW-1:0] addr [2];
  logic [DW-1:0] wdata [2];
  logic          has_owner, owner, other;
  logic          cnt_inc, cnt_dec;

  assign ren      = {i_p1_ren, i_p0_ren};
  assign wen      = {i_p1_wen, i_p0_wen};
  assign addr[0]  = i_p0_addr;
  assign addr[1]  = i_p1_addr;
  assign wdata[0] = i_p0_wdata;
  assign wdata[1] = i_p1_wdata;
  assign full     = {post_buf[1].full, post_buf[0].full};
  assign req      = ren | wen | full;

  assign o_p0_rdata = i_mem_rdata;
  assign o_p1_rdata = i_mem_rdata;
  assign o_p0_valid = i_mem_valid & has_owner & ~owner & (out_cnt != '0);
  assign o_p1_valid = i_mem_valid & has_owner &  owner & (out_cnt != '0);
  assign o_err      = err;

  // Current owner; from IDLE the winner is granted in the same cycle.
  always_comb begin
    has_owner = 1'b0;
    owner     = 1'b0;
    case (state)
      OWN0: has_owner = 1'b1;
      OWN1: begin
        has_owner = 1'b1;
        owner     = 1'b1;
      end
      default: begin
        if (req[0] && req[1]) begin
          has_owner = 1'b1;
          owner     = ~last_owner;
        end else if (req[0]) begin
          has_owner = 1'b1;
        end else if (req[1]) begin
          has_owner = 1'b1;
          owner     = 1'b1;
        end
      end
    endcase
    other = ~owner;
  end

  // Memory bus mux: the owner's posted write drains before any live request.
  always_comb begin
    o_mem_ren   = 1'b0;
    o_mem_wen   = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    o_p0_ready  = 1'b0;
    o_p1_ready  = 1'b0;
    issued      = '0;
    drain       = '0;
    if (has_owner) begin
      if (post_buf[owner].full) begin
        o_mem_wen     = 1'b1;
        o_mem_addr    = post_buf[owner].addr;
        o_mem_wdata   = post_buf[owner].data;
        drain[owner]  = i_mem_ready;
      end else if (ren[owner] || wen[owner]) begin
        o_mem_ren      = ren[owner];
        o_mem_wen      = wen[owner];
        o_mem_addr     = addr[owner];
        o_mem_wdata    = wdata[owner];
        issued[owner]  = wen[owner] & i_mem_ready;
        o_p0_ready     = ~owner & i_mem_ready;
        o_p1_ready     =  owner & i_mem_ready;
      end
    end
  end

  // Next state, outstanding-read count and protocol error detection.
  always_comb begin
    state_next      = state;
    last_owner_next = last_owner;
    out_cnt_next    = out_cnt;
    err_next        = err;
    post            = wen & ~issued;
    cnt_inc         = o_mem_ren & i_mem_ready;
    cnt_dec         = i_mem_valid & (out_cnt != '0);

    if (i_mem_valid && (out_cnt == '0)) err_next = 1'b1;
    if ((post & full) != 2'b00) err_next = 1'b1;
    if (cnt_inc && !cnt_dec) begin
      if (out_cnt == CNT_MAX) err_next = 1'b1;
      else out_cnt_next = out_cnt + OUT_W'(1);
    end else if (!cnt_inc && cnt_dec) begin
      out_cnt_next = out_cnt - OUT_W'(1);
    end

    case (state)
      IDLE: begin
        if (has_owner) begin
          state_next      = owner ? OWN1 : OWN0;
          last_owner_next = owner;
        end
      end
      OWN0, OWN1: begin
        if (!ren[owner] && !wen[owner] && !full[owner] && (out_cnt_next == '0)) begin
          if (req[other]) begin
            state_next      = other ? OWN1 : OWN0;
            last_owner_next = other;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= IDLE;
      last_owner <= 1'b1;
      out_cnt    <= '0;
      err        <= 1'b0;
      for (int p = 0; p < 2; p++) post_buf[p] <= '0;
    end else begin
      state      <= state_next;
      last_owner <= last_owner_next;
      out_cnt    <= out_cnt_next;
      err        <= err_next;
      for (int p = 0; p < 2; p++) begin
        if (post[p] && !full[p]) post_buf[p] <= '{full: 1'b1, addr: addr[p], data: wdata[p]};
        else if (drain[p]) post_buf[p].full <= 1'b0;
      end
    end
  end

endmodule
